// File: rtl/ex_writeback_if.sv
// ex_writeback_if: ALU-result handshake bus feeding the writeback stage.
//   master : upstream ALU side (drives result, opcode, operand signs, in_valid)
//   slave  : writeback stage (drives in_ready)
// Signals: in_valid/in_ready handshake, opco, funct, rd, a_msb, b_msb,
//          result_in (bit DW is carry-out), hi_in/lo_in product halves.
interface ex_writeback_if #(
  parameter int DW = 16,
  parameter int RA = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opco;
  logic [2:0]    funct;
  logic [RA-1:0] rd;
  logic          a_msb;
  logic          b_msb;
  logic [DW:0]   result_in;
  logic [DW:0]   hi_in;
  logic [DW:0]   lo_in;

  modport master (
    output in_valid, opco, funct, rd, a_msb, b_msb, result_in, hi_in, lo_in,
    input  in_ready
  );

  modport slave (
    input  in_valid, opco, funct, rd, a_msb, b_msb, result_in, hi_in, lo_in,
    output in_ready
  );
endinterface

// File: rtl/ex_writeback.sv
// ex_writeback: writeback stage behind the 16-bit ALU.
// Accepts one ALU result per handshake, drives the register-file write port,
// maintains the status flags (zer/neg/car/ovf) used by conditional adds and
// holds the HI/LO product registers. Multiplies write lo to rd, then hi to
// rd+1 (mod 2**RA) on the following cycle while upstream is stalled.
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   up (slave)         ALU result handshake bus
//   rf_we/rf_waddr/rf_wdata  register-file write port (registered)
//   zer/neg/car/ovf    registered status flags
//   hi_reg/lo_reg      registered product halves
module ex_writeback #(
  parameter int DW = 16,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          rst,
  ex_writeback_if.slave up,
  output logic          rf_we,
  output logic [RA-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          zer,
  output logic          neg,
  output logic          car,
  output logic          ovf,
  output logic [DW-1:0] hi_reg,
  output logic [DW-1:0] lo_reg
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WB_HI = 1'b1;

  localparam logic [3:0] OP_ALU = 4'd0;
  localparam logic [3:0] OP_SHL = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd10;

  logic [0:0]    state;
  logic          do_wr;
  logic          is_mul;
  logic [DW-1:0] wdat;
  logic          zer_n, neg_n, car_n, ovf_n;

  // Carry-out bits of the product halves are never used.
  logic          unused_bits;
  assign unused_bits = ^{up.hi_in[DW], up.lo_in[DW]};

  assign up.in_ready = (state == S_IDLE);

  // Classify the incoming op; conditional adds test the flags as registered
  // at the accept edge, so back-to-back ops see the previous op's flags.
  always_comb begin
    do_wr  = 1'b0;
    is_mul = 1'b0;
    wdat   = up.result_in[DW-1:0];
    car_n  = 1'b0;
    ovf_n  = 1'b0;
    case (up.opco)
      OP_ALU: begin
        case (up.funct)
          3'd0:    do_wr = 1'b1;
          3'd1:    do_wr = neg;
          3'd2:    do_wr = zer;
          default: do_wr = 1'b0;
        endcase
        car_n = up.result_in[DW];
        ovf_n = (up.a_msb == up.b_msb) && (up.result_in[DW-1] != up.a_msb);
      end
      OP_SHL: begin
        do_wr = 1'b1;
        car_n = up.result_in[DW];
      end
      OP_SHR, OP_OR, OP_AND: do_wr = 1'b1;
      OP_MUL: begin
        do_wr  = 1'b1;
        is_mul = 1'b1;
        wdat   = up.lo_in[DW-1:0];
      end
      default: do_wr = 1'b0;
    endcase
    if (is_mul) begin
      zer_n = ({up.hi_in[DW-1:0], up.lo_in[DW-1:0]} == '0);
      neg_n = up.hi_in[DW-1];
    end else begin
      zer_n = (wdat == '0);
      neg_n = wdat[DW-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      zer      <= 1'b0;
      neg      <= 1'b0;
      car      <= 1'b0;
      ovf      <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (up.in_valid && do_wr) begin
            rf_we    <= 1'b1;
            rf_waddr <= up.rd;
            rf_wdata <= wdat;
            zer      <= zer_n;
            neg      <= neg_n;
            car      <= car_n;
            ovf      <= ovf_n;
            if (is_mul) begin
              hi_reg <= up.hi_in[DW-1:0];
              lo_reg <= up.lo_in[DW-1:0];
              state  <= S_WB_HI;
            end
          end
        end
        S_WB_HI: begin
          // rf_waddr still holds rd from the lo write; hi_reg already holds
          // the hi half, so no separate pending-write storage is needed.
          rf_we    <= 1'b1;
          rf_waddr <= rf_waddr + RA'(1);
          rf_wdata <= hi_reg;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_writeback.sv
module tb_ex_writeback;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
    logic [3:0]  fl;   // {zer, neg, car, ovf}
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        zer, neg, car, ovf;
  logic [15:0] hi_reg, lo_reg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  wr_t exp_q[$];
  int  wcyc[$];

  ex_writeback_if #(.DW(16), .RA(3)) bus ();

  ex_writeback #(.DW(16), .RA(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .up       (bus.slave),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .zer      (zer),
    .neg      (neg),
    .car      (car),
    .ovf      (ovf),
    .hi_reg   (hi_reg),
    .lo_reg   (lo_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expw(input logic [2:0] a, input logic [15:0] d,
                      input logic z, input logic n, input logic c, input logic v);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.fl   = {z, n, c, v};
    exp_q.push_back(e);
  endtask

  // Monitor: every register-file write is popped against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    wr_t act;
    cyc++;
    if (rf_we === 1'b1) begin
      wcyc.push_back(cyc);
      act = {rf_waddr, rf_wdata, zer, neg, car, ovf};
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(act), 32'h7FFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write{addr,data,zncv}", 32'(act), 32'(e));
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [2:0] fn, input logic [2:0] r,
                       input logic a, input logic b, input logic [16:0] res,
                       input logic [16:0] hi, input logic [16:0] lo);
    bus.opco      = op;
    bus.funct     = fn;
    bus.rd        = r;
    bus.a_msb     = a;
    bus.b_msb     = b;
    bus.result_in = res;
    bus.hi_in     = hi;
    bus.lo_in     = lo;
    bus.in_valid  = 1'b1;
  endtask

  // Hold the driven op until in_ready, then let one accept edge pass.
  task automatic accept_wait();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("in_ready_timeout", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] fn, input logic [2:0] r,
                       input logic a, input logic b, input logic [16:0] res,
                       input logic [16:0] hi, input logic [16:0] lo);
    @(negedge clk);
    drive(op, fn, r, a, b, res, hi, lo);
    accept_wait();
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.opco      = '0;
    bus.funct     = '0;
    bus.rd        = '0;
    bus.a_msb     = 1'b0;
    bus.b_msb     = 1'b0;
    bus.result_in = '0;
    bus.hi_in     = '0;
    bus.lo_in     = '0;

    #1;
    chk("reset_rf_we",    32'(rf_we), 32'h0);
    chk("reset_waddr_wdata", 32'({rf_waddr, rf_wdata}), 32'h0);
    chk("reset_flags",    32'({zer, neg, car, ovf}), 32'h0);
    chk("reset_hi_lo",    32'({hi_reg, lo_reg}), 32'h0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Signed-overflow add.
    expw(3'd3, 16'h8000, 0, 1, 0, 1);
    issue(4'd0, 3'd0, 3'd3, 1'b0, 1'b0, 17'h08000, '0, '0);
    // Carry/zero add.
    expw(3'd1, 16'h0000, 1, 0, 1, 0);
    issue(4'd0, 3'd0, 3'd1, 1'b1, 1'b0, 17'h10000, '0, '0);
    // Conditional add on zer (zer=1 -> writes).
    expw(3'd5, 16'h8000, 0, 1, 1, 0);
    issue(4'd0, 3'd2, 3'd5, 1'b1, 1'b1, 17'h18000, '0, '0);
    // Conditional add on zer (zer=0 -> suppressed), then non-writing ops.
    issue(4'd0, 3'd2, 3'd5, 1'b0, 1'b0, 17'h00099, '0, '0);
    issue(4'd5, 3'd0, 3'd6, 1'b0, 1'b0, 17'h1FFFF, '0, '0);
    issue(4'd15, 3'd0, 3'd6, 1'b1, 1'b1, 17'h00000, '0, '0);
    issue(4'd0, 3'd5, 3'd6, 1'b0, 1'b0, 17'h00000, '0, '0);
    idle();
    chk("flags_held_after_nonwrites", 32'({zer, neg, car, ovf}), 32'h6);

    // Conditional add on neg (neg=1 -> writes, then neg=0 -> suppressed).
    expw(3'd2, 16'h0007, 0, 0, 0, 0);
    issue(4'd0, 3'd1, 3'd2, 1'b0, 1'b0, 17'h00007, '0, '0);
    issue(4'd0, 3'd1, 3'd4, 1'b0, 1'b0, 17'h00000, '0, '0);
    idle();
    chk("flags_after_suppressed_neg_add", 32'({zer, neg, car, ovf}), 32'h0);

    // Multiply with wrap; an add is held on the bus during the hi write.
    expw(3'd7, 16'hFFFE, 0, 0, 0, 0);
    expw(3'd0, 16'h0001, 0, 0, 0, 0);
    expw(3'd6, 16'h0010, 0, 0, 0, 0);
    issue(4'd10, 3'd0, 3'd7, 1'b0, 1'b0, 17'h00000, 17'h00001, 17'h0FFFE);
    @(negedge clk);
    chk("mul_in_ready_low", 32'(bus.in_ready), 32'h0);
    chk("mul_hi_lo_reg", 32'({hi_reg, lo_reg}), 32'h0001FFFE);
    drive(4'd0, 3'd0, 3'd6, 1'b0, 1'b0, 17'h00010, '0, '0);
    accept_wait();
    idle();

    // Back-to-back or then shl.
    expw(3'd1, 16'h00F0, 0, 0, 0, 0);
    expw(3'd2, 16'h0000, 1, 0, 1, 0);
    issue(4'd3, 3'd0, 3'd1, 1'b0, 1'b0, 17'h100F0, '0, '0);
    issue(4'd1, 3'd0, 3'd2, 1'b0, 1'b0, 17'h10000, '0, '0);
    idle();
    @(negedge clk);
    #1;
    chk("or_shl_consecutive", 32'(wcyc[$] - wcyc[$-1]), 32'h1);

    // Shift right and AND ignore carry-out.
    expw(3'd4, 16'h8001, 0, 1, 0, 0);
    expw(3'd5, 16'h0000, 1, 0, 0, 0);
    issue(4'd2, 3'd0, 3'd4, 1'b0, 1'b0, 17'h18001, '0, '0);
    issue(4'd4, 3'd0, 3'd5, 1'b0, 1'b0, 17'h00000, '0, '0);

    // Multiply with zero product, then with negative hi.
    expw(3'd3, 16'h0000, 1, 0, 0, 0);
    expw(3'd4, 16'h0000, 1, 0, 0, 0);
    issue(4'd10, 3'd0, 3'd3, 1'b0, 1'b0, 17'h00000, 17'h10000, 17'h10000);
    expw(3'd1, 16'h0001, 0, 1, 0, 0);
    expw(3'd2, 16'h8000, 0, 1, 0, 0);
    issue(4'd10, 3'd0, 3'd1, 1'b0, 1'b0, 17'h00000, 17'h18000, 17'h00001);
    idle();
    repeat (2) @(negedge clk);
    chk("mul_neg_hi_lo_reg", 32'({hi_reg, lo_reg}), 32'h80000001);

    // Reset asserted in WB_HI aborts the pending hi write.
    expw(3'd2, 16'h5678, 0, 0, 0, 0);
    issue(4'd10, 3'd0, 3'd2, 1'b0, 1'b0, 17'h00000, 17'h01234, 17'h05678);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_rf_we",    32'(rf_we), 32'h0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("midrst_flags",    32'({zer, neg, car, ovf}), 32'h0);
    chk("midrst_hi_lo",    32'({hi_reg, lo_reg}), 32'h0);
    chk("midrst_waddr_wdata", 32'({rf_waddr, rf_wdata}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_writeback.md
# ex_writeback

Writeback stage directly downstream of the 16-bit ALU. It accepts one ALU result per handshake and drives the register-file write port. It maintains the architectural status flags (zer, neg, car, ovf) that feed back into the ALU's conditional-add logic, and holds the HI/LO product registers. Multiply results are written back over two cycles, with the stage stalling upstream during the second write.

## Interface
Parameters:
- DW, 16, architectural data width; ALU result buses are DW+1 bits.
- RA, 3, register-file address width (8 registers).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result present this cycle.
- in_ready  output  1  stage can accept; high only in IDLE.
- opco  input  4  opcode of the instruction being retired.
- funct  input  3  function field (used when opco=0).
- rd  input  RA  destination register.
- a_msb, b_msb  input  1 each  sign bits of the ALU operands (var_1[15], selected var_2[15]).
- result_in  input  DW+1  ALU result; bit 16 is carry-out.
- hi_in, lo_in  input  DW+1 each  product halves; only bits [15:0] are used.
- rf_we  output  1  register-file write strobe.
- rf_waddr  output  RA  write address.
- rf_wdata  output  DW  write data.
- zer, neg, car, ovf  output  1 each  registered status flags.
- hi_reg, lo_reg  output  DW each  registered product halves.

## Operation
- Transfer occurs when in_valid and in_ready are both high on a rising clk edge ("accept").
- States:
  - IDLE: in_ready=1.
    - Accept of opco=10 → WB_HI.
    - Any other accept → stays in IDLE.
  - WB_HI: in_ready=0; issues the hi write, then returns to IDLE unconditionally.
- Write classification on accept:
  - opco 0, funct 0: add; writes rd.
  - opco 0, funct 1: writes rd only if the registered neg=1 at the accept edge.
  - opco 0, funct 2: writes rd only if the registered zer=1 at the accept edge.
  - opco 0, other funct: no write.
  - opco 1/2/3/4: shl, shr, or, and; each writes rd.
  - opco 10: multiply.
    - Writes lo_in[15:0] to rd.
    - Then writes hi_in[15:0] to rd+1 (mod 8, so 7 wraps to 0).
    - Loads hi_reg/lo_reg.
  - opco 5/7/8: address and branch arithmetic; no write, flags unchanged.
  - All other opcodes: no write, flags unchanged.
- Flag rules apply only to writing ops; suppressed conditional adds leave all flags unchanged.
  - zer = (written value == 0).
  - neg = written value bit 15.
  - Adds:
    - car = result_in[16].
    - ovf = (a_msb==b_msb) && (result_in[15]!=a_msb).
  - Shift left: car = result_in[16]; ovf=0.
  - Shift right, or, and: car=0, ovf=0.
  - Multiply:
    - zer = ({hi,lo}==0).
    - neg = hi_in[15].
    - car=0, ovf=0.
- Write data is always the low 16 bits of the source; bit 16 never reaches the register file.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, in_ready=1.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - zer=neg=car=ovf=0.
  - hi_reg=lo_reg=0.
- Latency:
  - Accept at edge N → rf_we=1 with data during cycle N+1 (registered outputs).
  - Flags, hi_reg and lo_reg are valid in cycle N+1.
- Multiply:
  - Lo write in cycle N+1; hi write in cycle N+2.
  - in_ready=0 during cycle N+1 only.
- rf_we is a one-cycle pulse per write. With continuous valid non-multiply ops, one write per cycle.
- Back-to-back conditional add: the op accepted at N+1 sees the flags produced by the op accepted at N.
- Reset asserted in WB_HI aborts the pending hi write. hi_reg/lo_reg are cleared even if already loaded.
- in_valid while in_ready=0 is ignored; upstream must hold its data.

## Test plan
- Reset mid-stream: assert rst in WB_HI → rf_we=0 immediately, in_ready=1, all flags 0, no hi write follows.
- Signed-overflow add: opco=0, funct=0, rd=3, result_in=17'h08000, a_msb=0, b_msb=0 → next cycle rf_we=1, waddr=3, wdata=16'h8000, neg=1, ovf=1, car=0, zer=0.
- Carry/zero add: result_in=17'h10000 → wdata=0, zer=1, car=1.
  - Follow with opco=0, funct=2, rd=5 → write to r5.
  - Repeat with zer=0 → no write, flags held.
- Multiply with wrap: opco=10, rd=7, hi_in=16'h0001, lo_in=16'hFFFE.
  - N+1: r7←FFFE, in_ready=0.
  - N+2: r0←0001.
  - hi_reg=0001, lo_reg=FFFE, zer=0, neg=0.
- Non-writing opcode: opco=5 with arbitrary result → rf_we stays 0, flags unchanged.
- Back-to-back or (opco=3) then shl (opco=1, result_in=17'h1_0000):
  - Consecutive rf_we pulses.
  - After the shl: car=1, zer=1.
